// File: rtl/ag32gbd_frame_scanner_if.sv
// Signal bundle between the frame scanner, its controller, the pixel sampler
// and the frame buffer. master = scanner side, slave = environment side.
interface ag32gbd_frame_scanner_if;
  logic        FrameStart;
  logic        FrameAbort;
  logic        FrameBusy;
  logic        FrameDone;
  logic        SampleStart;
  logic [6:0]  PixelX;
  logic [6:0]  PixelY;
  logic        SampleDone;
  logic [1:0]  SampledValue;
  logic        FbWrite;
  logic [11:0] FbAddr;
  logic [7:0]  FbData;
  logic [7:0]  TimeoutCount;

  modport master (
    input  FrameStart, FrameAbort, SampleDone, SampledValue,
    output FrameBusy, FrameDone, SampleStart, PixelX, PixelY,
           FbWrite, FbAddr, FbData, TimeoutCount
  );

  modport slave (
    output FrameStart, FrameAbort, SampleDone, SampledValue,
    input  FrameBusy, FrameDone, SampleStart, PixelX, PixelY,
           FbWrite, FbAddr, FbData, TimeoutCount
  );
endinterface

// File: rtl/ag32gbd_frame_scanner.sv
// Raster-scans a 128x112 2-bit image through a pixel sampler handshake and
// writes it as tiled bit-planes (two bytes per 8-pixel row slice).
module ag32gbd_frame_scanner #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                     sys_clock,
  input logic                     sys_reset,
  ag32gbd_frame_scanner_if.master bus
);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_START        = 3'd1;
  localparam logic [2:0] S_WAIT_DONE    = 3'd2;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] S_WRITE_LO     = 3'd4;
  localparam logic [2:0] S_WRITE_HI     = 3'd5;
  localparam logic [2:0] S_NEXT         = 3'd6;

  // Tiles of 8x8 pixels, 16 bytes each: row-in-tile pairs, plane in bit 0.
  function automatic logic [11:0] fb_addr(input logic [6:0] x, input logic [6:0] y,
                                          input logic plane);
    return {y[6:3], x[6:3], y[2:0], plane};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]       state_r;
  logic [6:0]       x_r, y_r;
  logic [7:0]       plane0_r, plane1_r;
  logic [TMO_W-1:0] tmo_r;
  logic             ss_phase_r;
  logic [7:0]       timeouts_r;
  logic             start_prev_r, done_prev_r;
  logic             busy_r, done_r, sample_start_r, fb_write_r;
  logic [11:0]      fb_addr_r;
  logic [7:0]       fb_data_r;
  logic             start_rise_s, done_rise_s, tmo_hit_s;

  assign start_rise_s = bus.FrameStart & ~start_prev_r;
  assign done_rise_s  = bus.SampleDone & ~done_prev_r;
  assign tmo_hit_s    = (tmo_r == TMO_LAST);

  // Scan sequencer: state, pixel position, plane shifters and all outputs.
  always_ff @(posedge sys_clock) begin
    // Edge history keeps tracking through reset so a level held across
    // reset release is not mistaken for a fresh edge.
    start_prev_r <= bus.FrameStart;
    done_prev_r  <= bus.SampleDone;
    if (sys_reset) begin
      state_r        <= S_IDLE;
      x_r            <= 7'd0;
      y_r            <= 7'd0;
      plane0_r       <= 8'd0;
      plane1_r       <= 8'd0;
      tmo_r          <= '0;
      ss_phase_r     <= 1'b0;
      timeouts_r     <= 8'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      sample_start_r <= 1'b0;
      fb_write_r     <= 1'b0;
      fb_addr_r      <= 12'd0;
      fb_data_r      <= 8'd0;
    end else begin
      done_r <= 1'b0;
      if ((state_r != S_IDLE) && bus.FrameAbort) begin
        state_r        <= S_IDLE;
        busy_r         <= 1'b0;
        sample_start_r <= 1'b0;
        fb_write_r     <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start_rise_s) begin
              x_r            <= 7'd0;
              y_r            <= 7'd0;
              plane0_r       <= 8'd0;
              plane1_r       <= 8'd0;
              timeouts_r     <= 8'd0;
              busy_r         <= 1'b1;
              sample_start_r <= 1'b1;
              ss_phase_r     <= 1'b0;
              state_r        <= S_START;
            end
          end
          S_START: begin
            if (ss_phase_r) begin
              sample_start_r <= 1'b0;
              tmo_r          <= '0;
              state_r        <= S_WAIT_DONE;
            end else begin
              ss_phase_r <= 1'b1;
            end
          end
          S_WAIT_DONE: begin
            if (done_rise_s) begin
              plane0_r <= {plane0_r[6:0], bus.SampledValue[0]};
              plane1_r <= {plane1_r[6:0], bus.SampledValue[1]};
              tmo_r    <= '0;
              state_r  <= S_WAIT_RELEASE;
            end else if (tmo_hit_s) begin
              plane0_r   <= {plane0_r[6:0], 1'b0};
              plane1_r   <= {plane1_r[6:0], 1'b0};
              timeouts_r <= sat_inc(timeouts_r);
              tmo_r      <= '0;
              state_r    <= S_WAIT_RELEASE;
            end else begin
              tmo_r <= tmo_r + TMO_W'(1);
            end
          end
          S_WAIT_RELEASE: begin
            if (bus.SampleDone && !tmo_hit_s) begin
              tmo_r <= tmo_r + TMO_W'(1);
            end else begin
              if (bus.SampleDone) timeouts_r <= sat_inc(timeouts_r);
              if (x_r[2:0] == 3'd7) begin
                fb_write_r <= 1'b1;
                fb_addr_r  <= fb_addr(x_r, y_r, 1'b0);
                fb_data_r  <= plane0_r;
                state_r    <= S_WRITE_LO;
              end else begin
                state_r <= S_NEXT;
              end
            end
          end
          S_WRITE_LO: begin
            fb_addr_r <= fb_addr(x_r, y_r, 1'b1);
            fb_data_r <= plane1_r;
            state_r   <= S_WRITE_HI;
          end
          S_WRITE_HI: begin
            fb_write_r <= 1'b0;
            state_r    <= S_NEXT;
          end
          S_NEXT: begin
            if ((x_r != 7'd127) || (y_r != 7'd111)) begin
              if (x_r != 7'd127) begin
                x_r <= x_r + 7'd1;
              end else begin
                x_r <= 7'd0;
                y_r <= y_r + 7'd1;
              end
              sample_start_r <= 1'b1;
              ss_phase_r     <= 1'b0;
              state_r        <= S_START;
            end else begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.FrameBusy    = busy_r;
  assign bus.FrameDone    = done_r;
  assign bus.SampleStart  = sample_start_r;
  assign bus.PixelX       = x_r;
  assign bus.PixelY       = y_r;
  assign bus.FbWrite      = fb_write_r;
  assign bus.FbAddr       = fb_addr_r;
  assign bus.FbData       = fb_data_r;
  assign bus.TimeoutCount = timeouts_r;
endmodule
